bht_update_queue: RTL and testbench
===================================

BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >= 2).
REQ-002 The block SHALL have parameter VLEN, default config_pkg::VLEN, meaning PC width.
REQ-003 The block SHALL have port clk_i, input, 1, clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-005 The block SHALL have port flush_bp_i, input, 1, which discards all queued updates.
REQ-006 The block SHALL have port res_valid_i, input, 2, per-lane resolved-branch strobe from commit (lane 0 older).
REQ-007 The block SHALL have port res_pc_i, input, 2xVLEN, per-lane branch PC.
REQ-008 The block SHALL have port res_is_cond_i, input, 2, per-lane flag marking a conditional branch.
REQ-009 The block SHALL have port res_taken_i, input, 2, per-lane resolved direction.
REQ-010 The block SHALL have port res_ready_o, output, 1, high when two free entries exist.
REQ-011 The block SHALL have port bht_update_o, output, bht_update_t, {valid, pc, taken} driven to the predictor's update port.
REQ-012 The block SHALL have port occupancy_o, output, $clog2(DEPTH)+1, current entry count.

Function
REQ-013 Lane i SHALL be accepted when res_valid_i[i] && res_is_cond_i[i] && res_ready_o && !flush_bp_i; other lanes are dropped silently.
REQ-014 res_ready_o SHALL be combinational: high iff occupancy_o <= DEPTH-2.
REQ-015 Strobes presented while res_ready_o is low SHALL be ignored; commit holds them per protocol.
REQ-016 When both lanes are accepted in one cycle, lane 0 SHALL be written before lane 1; when only one is accepted, it SHALL take the next single slot.
REQ-017 bht_update_o.valid SHALL equal (occupancy_o != 0), with pc/taken taken from the head entry.
REQ-018 The predictor SHALL always accept an update, so the head SHALL be dequeued every cycle in which bht_update_o.valid is high.
REQ-019 An entry enqueued at edge N SHALL appear on bht_update_o in cycle N+1 at the earliest; an empty queue SHALL not bypass.
REQ-020 Updates SHALL leave in strict acceptance order.
REQ-021 Simultaneous dequeue plus enqueue of k entries SHALL change occupancy by k-1.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-023 Occupancy SHALL never exceed DEPTH or underflow below 0.
REQ-024 When flush_bp_i is high, the next edge SHALL set occupancy to 0 and both pointers to 0; enqueue and dequeue in that cycle SHALL be discarded.
REQ-025 When bht_update_o.valid is high during flush_bp_i, it SHALL still be presented, and the predictor treats it as a don't-care.
REQ-026 Entry payload SHALL be {pc[VLEN-1:0], taken}, and pc SHALL be passed unmodified with no index slicing.

Reset
REQ-027 Reset SHALL clear the pointers and occupancy asynchronously, giving bht_update_o.valid=0, occupancy_o=0 and res_ready_o=1.
REQ-028 Entry storage SHALL need no reset; outputs SHALL not depend on unwritten entries.
REQ-029 Reset asserted mid-operation SHALL drop all entries immediately, with no update emitted after rst_ni rises until a new accept.

Structure
REQ-030 bht_update_t and the branch-resolution lane struct SHALL live in the shared ariane/config package, not locally.
REQ-031 DEPTH-derived widths SHALL be localparams in the module.
REQ-032 The block SHALL be one module with no sub-module; the 2-write/1-read FIFO is inline.

Verification
REQ-033 Reset then idle: bht_update_o.valid=0, occupancy_o=0 and res_ready_o=1 for 10 cycles.
REQ-034 Two-lane enqueue of pc 0x100 taken and pc 0x104 not-taken at cycle 0 -> cycle 1 outputs {1,0x100,1} and cycle 2 outputs {1,0x104,0}; cycle 3 valid=0.
REQ-035 Lane mix res_valid_i=2'b11 with res_is_cond_i=2'b10 -> only lane 1 enqueued and occupancy 1 next cycle.
REQ-036 DEPTH=4 with dual enqueue on consecutive cycles -> occupancy 2 then 3 (one drained), res_ready_o drops at occupancy 3, and third-cycle strobes are ignored.
REQ-037 Flush at occupancy 3 with simultaneous dual enqueue -> next cycle occupancy 0, valid=0 and none of those PCs emitted.
REQ-038 Randomized 10k cycles against a reference queue model -> identical output sequence, pointer wrap exercised, and no overflow.

Source files
------------

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared configuration and branch-predictor update types
package config_pkg;

    localparam int unsigned VLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            is_cond;
        logic            taken;
    } branch_res_t;

endpackage

// File: rtl/bht_update_queue.sv
// rtl/bht_update_queue.sv - 2-write/1-read queue of resolved conditional branches feeding the BHT
module bht_update_queue
    import config_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned VLEN  = config_pkg::VLEN
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_bp_i,
    input  logic [1:0]        res_valid_i,
    input  logic [2*VLEN-1:0] res_pc_i,
    input  logic [1:0]        res_is_cond_i,
    input  logic [1:0]        res_taken_i,
    output logic              res_ready_o,
    output bht_update_t       bht_update_o,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    logic [VLEN:0]      mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr, wr_ptr_lane1;
    logic [CNT_W-1:0]   count, n_acc;
    logic [1:0]         acc;
    logic               deq;

    assign res_ready_o = (count <= READY_MAX);
    assign acc         = res_valid_i & res_is_cond_i & {2{res_ready_o && !flush_bp_i}};
    assign n_acc       = CNT_W'(acc[0]) + CNT_W'(acc[1]);
    assign deq         = (count != '0);
    // Lane 1 lands behind lane 0 only when lane 0 also took a slot this cycle.
    assign wr_ptr_lane1 = acc[0] ? wr_ptr + PTR_W'(1) : wr_ptr;

    always_ff @(posedge clk_i) begin
        if (acc[0]) mem[wr_ptr]       <= {res_pc_i[VLEN-1:0], res_taken_i[0]};
        if (acc[1]) mem[wr_ptr_lane1] <= {res_pc_i[2*VLEN-1:VLEN], res_taken_i[1]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_bp_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(deq);
            wr_ptr <= wr_ptr + PTR_W'(n_acc);
            count  <= count + n_acc - CNT_W'(deq);
        end
    end

    // Payload is gated so an empty queue never exposes stale storage.
    always_comb begin
        bht_update_o       = '0;
        bht_update_o.valid = deq;
        if (deq) begin
            bht_update_o.pc    = mem[rd_ptr][VLEN:1];
            bht_update_o.taken = mem[rd_ptr][0];
        end
    end

    assign occupancy_o = count;

endmodule

// File: tb/tb_bht_update_queue.sv
// tb/tb_bht_update_queue.sv - randomized and directed bench for bht_update_queue
module tb_bht_update_queue;
    import config_pkg::*;

    localparam int DEPTH = 4;
    localparam int VL    = config_pkg::VLEN;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_bp_i;
    logic [1:0]        res_valid_i;
    logic [2*VL-1:0]   res_pc_i;
    logic [1:0]        res_is_cond_i;
    logic [1:0]        res_taken_i;
    logic              res_ready_o;
    bht_update_t       bht_update_o;
    logic [$clog2(DEPTH):0] occupancy_o;

    int checks = 0;
    int errors = 0;
    logic [VL:0] q[$];

    bht_update_queue #(.DEPTH(DEPTH), .VLEN(VL)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_bp_i    (flush_bp_i),
        .res_valid_i   (res_valid_i),
        .res_pc_i      (res_pc_i),
        .res_is_cond_i (res_is_cond_i),
        .res_taken_i   (res_taken_i),
        .res_ready_o   (res_ready_o),
        .bht_update_o  (bht_update_o),
        .occupancy_o   (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input logic [1:0] v, input logic [1:0] c, input logic [1:0] t,
                         input logic [VL-1:0] p0, input logic [VL-1:0] p1, input logic fl);
        res_valid_i   = v;
        res_is_cond_i = c;
        res_taken_i   = t;
        res_pc_i      = {p1, p0};
        flush_bp_i    = fl;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
    endtask

    // Reference: a plain queue; commit offers up to two lanes in age order.
    task automatic model_step();
        bit rdy;
        if (flush_bp_i) begin
            q.delete();
        end else begin
            rdy = (q.size() <= DEPTH - 2);
            if (q.size() != 0) void'(q.pop_front());
            if (rdy) begin
                for (int l = 0; l < 2; l++)
                    if (res_valid_i[l] && res_is_cond_i[l])
                        q.push_back({res_pc_i[l*VL +: VL], res_taken_i[l]});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bht_update_o.valid !== 1'b0 || occupancy_o !== 3'd0 || res_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: valid=%b occ=%0d ready=%b, want 0/0/1",
                         i, bht_update_o.valid, occupancy_o, res_ready_o);
            end
        end
    endtask

    task automatic test_two_lane();
        drive(2'b11, 2'b11, 2'b01, 32'h100, 32'h104, 1'b0);
        tick();
        idle();
        checks++;
        if (bht_update_o !== {1'b1, 32'h100, 1'b1} || occupancy_o !== 3'd2) begin
            errors++;
            $display("FAIL two_lane_c1: upd=%h occ=%0d, want {1,100,1} occ 2", bht_update_o, occupancy_o);
        end
        tick();
        checks++;
        if (bht_update_o !== {1'b1, 32'h104, 1'b0} || occupancy_o !== 3'd1) begin
            errors++;
            $display("FAIL two_lane_c2: upd=%h occ=%0d, want {1,104,0} occ 1", bht_update_o, occupancy_o);
        end
        tick();
        checks++;
        if (bht_update_o.valid !== 1'b0 || occupancy_o !== 3'd0) begin
            errors++;
            $display("FAIL two_lane_c3: valid=%b occ=%0d, want 0 0", bht_update_o.valid, occupancy_o);
        end
    endtask

    task automatic test_lane_mix();
        drive(2'b11, 2'b10, 2'b10, 32'h1F0, 32'h200, 1'b0);
        tick();
        idle();
        checks++;
        if (occupancy_o !== 3'd1 || bht_update_o !== {1'b1, 32'h200, 1'b1}) begin
            errors++;
            $display("FAIL lane_mix: occ=%0d upd=%h, want occ 1 {1,200,1}", occupancy_o, bht_update_o);
        end
        tick();
    endtask

    task automatic test_fill();
        drive(2'b11, 2'b11, 2'b00, 32'hA0, 32'hA4, 1'b0);
        tick();
        checks++;
        if (occupancy_o !== 3'd2 || res_ready_o !== 1'b1 || bht_update_o.pc !== 32'hA0) begin
            errors++;
            $display("FAIL fill_a: occ=%0d ready=%b pc=%h, want 2 1 a0", occupancy_o, res_ready_o, bht_update_o.pc);
        end
        drive(2'b11, 2'b11, 2'b11, 32'hB0, 32'hB4, 1'b0);
        tick();
        checks++;
        if (occupancy_o !== 3'd3 || res_ready_o !== 1'b0 || bht_update_o.pc !== 32'hA4) begin
            errors++;
            $display("FAIL fill_b: occ=%0d ready=%b pc=%h, want 3 0 a4", occupancy_o, res_ready_o, bht_update_o.pc);
        end
        drive(2'b11, 2'b11, 2'b11, 32'hC0, 32'hC4, 1'b0);
        tick();
        idle();
        checks++;
        if (occupancy_o !== 3'd2 || bht_update_o !== {1'b1, 32'hB0, 1'b1}) begin
            errors++;
            $display("FAIL fill_ignored: occ=%0d upd=%h, want 2 {1,b0,1}", occupancy_o, bht_update_o);
        end
        repeat (2) tick();
        checks++;
        if (occupancy_o !== 3'd0) begin
            errors++;
            $display("FAIL fill_drain: occ=%0d, want 0", occupancy_o);
        end
    endtask

    task automatic test_flush();
        drive(2'b11, 2'b11, 2'b00, 32'hD0, 32'hD4, 1'b0);
        tick();
        drive(2'b11, 2'b11, 2'b00, 32'hD8, 32'hDC, 1'b0);
        tick();
        checks++;
        if (occupancy_o !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre: occ=%0d, want 3", occupancy_o);
        end
        drive(2'b11, 2'b11, 2'b11, 32'hE0, 32'hE4, 1'b1);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (occupancy_o !== 3'd0 || bht_update_o.valid !== 1'b0 || res_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL flush_post cyc %0d: occ=%0d valid=%b pc=%h, want 0 0", i,
                         occupancy_o, bht_update_o.valid, bht_update_o.pc);
            end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        drive(2'b11, 2'b11, 2'b01, 32'hF0, 32'hF4, 1'b0);
        tick();
        idle();
        #2;
        rst_ni = 1'b0;
        q.delete();
        #1;
        checks++;
        if (occupancy_o !== 3'd0 || bht_update_o.valid !== 1'b0 || res_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: occ=%0d valid=%b ready=%b, want 0 0 1",
                     occupancy_o, bht_update_o.valid, res_ready_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) begin
            tick();
            checks++;
            if (bht_update_o.valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_emit: valid=%b pc=%h, want valid 0", bht_update_o.valid, bht_update_o.pc);
            end
        end
    endtask

    task automatic test_random();
        int pops = 0;
        logic [VL:0] head;
        for (int i = 0; i < 10000; i++) begin
            drive(2'($urandom), 2'($urandom_range(0, 3) == 0 ? 2'b00 : 2'($urandom)),
                  2'($urandom), VL'($urandom), VL'($urandom), ($urandom_range(0, 40) == 0));
            if (q.size() != 0 && !flush_bp_i) pops++;
            tick();
            head = (q.size() != 0) ? q[0] : '0;
            checks++;
            if (bht_update_o.valid !== (q.size() != 0) || occupancy_o !== 3'(q.size())
                || res_ready_o !== (q.size() <= DEPTH - 2)
                || (q.size() != 0 && {bht_update_o.pc, bht_update_o.taken} !== head)) begin
                errors++;
                $display("FAIL random cyc %0d: valid=%b occ=%0d ready=%b pc=%h t=%b, want occ %0d head %h",
                         i, bht_update_o.valid, occupancy_o, res_ready_o, bht_update_o.pc,
                         bht_update_o.taken, q.size(), head);
            end
        end
        checks++;
        if (pops <= DEPTH) begin
            errors++;
            $display("FAIL random_wrap: dequeues=%0d, want > %0d", pops, DEPTH);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_two_lane();
        test_lane_mix();
        test_fill();
        test_flush();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
